// File: rtl/keccak_out_pkg.sv
// Shared types, digest lengths and helpers for the Keccak digest collector.
// Length and byte-mask rules live here so top and bench views agree.
package keccak_out_pkg;

  typedef enum logic [2:0] {
    SHA3_224 = 3'd0,
    SHA3_256 = 3'd1,
    SHA3_384 = 3'd2,
    SHA3_512 = 3'd3,
    SHAKE128 = 3'd4,
    SHAKE256 = 3'd5
  } cmode_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_e;

  localparam int SHA3_224_L = 224;
  localparam int SHA3_256_L = 256;
  localparam int SHA3_384_L = 384;
  localparam int SHA3_512_L = 512;

  // Word counters cover N up to 64 (2048-bit SHAKE output at W=32)
  localparam int CNT_W = $clog2(2048 / 32 + 1);
  localparam int R_W   = 7;

  function automatic logic [15:0] digest_bits(
    input logic [2:0]  cmode,
    input logic [15:0] d
  );
    case (cmode_e'(cmode))
      SHA3_224: digest_bits = 16'(SHA3_224_L);
      SHA3_256: digest_bits = 16'(SHA3_256_L);
      SHA3_384: digest_bits = 16'(SHA3_384_L);
      SHA3_512: digest_bits = 16'(SHA3_512_L);
      SHAKE128,
      SHAKE256: digest_bits = d;
      default:  digest_bits = '0;
    endcase
  endfunction

  function automatic logic [7:0] keep_mask(
    input logic [R_W-1:0] r,
    input int             w
  );
    int nb;
    nb = (int'(r) + 7) >> 3;
    if (nb > w / 8) nb = w / 8;
    keep_mask = 8'((1 << nb) - 1);
  endfunction

endpackage

// File: rtl/keccak_digest_collector_if.sv
// Command, ingress and egress bundle of the digest collector.
// master drives commands/words in; slave is the collector.
interface keccak_digest_collector_if #(
  parameter int W    = 32,
  parameter int DMAX = 11
);
  logic            start;
  logic [2:0]      cmode;
  logic [DMAX-1:0] d;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [W/8-1:0]  out_keep;
  logic            out_last;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start, cmode, d, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last,
    input  busy, done, err
  );

  modport slave (
    input  start, cmode, d, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last,
    output busy, done, err
  );
endinterface

// File: rtl/keccak_word_fifo.sv
// Synchronous word FIFO; read data comes straight from the storage regs.
// Pointers carry an extra wrap bit to tell full from empty.
module keccak_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/keccak_digest_collector.sv
// Collects one digest worth of Keccak words, pads the last word and
// re-streams them through a FIFO with a valid/ready egress.
module keccak_digest_collector
  import keccak_out_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int DMAX  = 11
) (
  input  logic clk,
  input  logic rst,
  keccak_digest_collector_if.slave bus
);
  localparam int LW = $clog2(W);
  localparam int BW = W / 8;

  state_e           state;
  logic [CNT_W-1:0] n_words;
  logic [R_W-1:0]   r_bits;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             done_q;
  logic             err_q;

  logic [15:0]      l_bits;
  logic [LW-1:0]    l_rem;
  logic [CNT_W-1:0] n_calc;
  logic [R_W-1:0]   r_calc;
  logic             start_ok;

  logic             push;
  logic             pop;
  logic             wr_last;
  logic [W-1:0]     wr_data;
  logic [W:0]       rd_word;
  logic             full;
  logic             empty;

  assign l_bits   = digest_bits(bus.cmode, 16'(bus.d));
  assign l_rem    = l_bits[LW-1:0];
  assign n_calc   = CNT_W'((l_bits + 16'(W - 1)) >> LW);
  assign r_calc   = (l_rem == '0) ? R_W'(W) : R_W'(l_rem);
  assign start_ok = (l_bits != '0);

  assign bus.in_ready = (state == COLLECT) && !full &&
                        (in_cnt < n_words);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = !empty && bus.out_ready;

  // Last word: clear every bit at or above R before it is stored
  always_comb begin
    wr_last = (in_cnt == n_words - 1'b1);
    wr_data = '0;
    for (int i = 0; i < W; i++) begin
      wr_data[i] = bus.in_data[i] &
                   (!wr_last || (R_W'(i) < r_bits));
    end
  end

  keccak_word_fifo #(
    .WIDTH (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({wr_last, wr_data}),
    .pop   (pop),
    .dout  (rd_word),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = !empty;
  assign bus.out_last  = !empty && rd_word[W];
  assign bus.out_data  = empty ? '0 : rd_word[W-1:0];
  assign bus.out_keep  = empty       ? '0 :
                         rd_word[W]  ? BW'(keep_mask(r_bits, W)) :
                                       '1;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n_words <= '0;
      r_bits  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (start_ok) begin
              n_words <= n_calc;
              r_bits  <= r_calc;
              in_cnt  <= '0;
              out_cnt <= '0;
              state   <= COLLECT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.start) err_q <= 1'b1;
          if (push) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt + 1'b1 == n_words) state <= DRAIN;
          end
          if (pop) out_cnt <= out_cnt + 1'b1;
        end
        DRAIN: begin
          if (bus.start) err_q <= 1'b1;
          if (pop) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == n_words - 1'b1) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
